// File: rtl/fb_scanout_arbiter_pkg.sv
// Shared types and helpers for the frame-buffer scanout arbiter:
// the RGB332 pixel layout, its 24-bit expansion, and the scan FSM encoding.
package fb_pkg;

    localparam int unsigned FB_W     = 320;
    localparam int unsigned FB_H     = 240;
    localparam int unsigned FB_WORDS = FB_W * FB_H;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    typedef enum logic [2:0] {
        SCAN_RD  = 3'b001,
        SCAN_GAP = 3'b010,
        BLANK    = 3'b100
    } scan_state_e;

    // Bit replication keeps full-scale codes at 8'hFF and zero at 8'h00.
    function automatic logic [23:0] expand_rgb332(input rgb332_t p);
        return {p.r, p.r, p.r[2:1], p.g, p.g, p.g[2:1], p.b, p.b, p.b, p.b};
    endfunction

endpackage

// File: rtl/fb_scanout_arbiter_if.sv
// Loader write handshake plus single-port frame-buffer bus.
// slave = arbiter view; master = loader/memory environment view.
interface fb_scanout_arbiter_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 8
);

    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  wr_valid, wr_addr, wr_data, mem_rdata,
        output wr_ready, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output wr_valid, wr_addr, wr_data, mem_rdata,
        input  wr_ready, mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/fb_scanout_arbiter_sync_delay.sv
// Fixed-depth shift register for sync/blank alignment; every stage resets
// to RESET_VAL so the pins show idle syncs while the pipeline refills.
module sync_delay #(
    parameter int unsigned     DEPTH     = 3,
    parameter int unsigned     WIDTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(3'b110)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/fb_scanout_arbiter.sv
// Scanout/loader arbiter for a registered-read frame buffer, 3-cycle counter-to-pin latency.
// Optional FB_BORDER_EN forces a white one-pixel frame around the active area.
module fb_scanout_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned DATA_W      = 8
) (
    input  logic                  vga_clk,
    input  logic                  reset_n,
    input  logic [9:0]            hcount,
    input  logic [9:0]            vcount,
    input  logic                  hs_in,
    input  logic                  vs_in,
    input  logic                  blank_n_in,
    fb_scanout_arbiter_if.slave   bus,
    output logic [7:0]            vga_r,
    output logic [7:0]            vga_g,
    output logic [7:0]            vga_b,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic                  vga_blank_n,
    output logic                  frame_start
);

    localparam int unsigned FB_W_P     = H_ACTIVE >> SCALE_SHIFT;
    localparam int unsigned FB_WORDS_P = FB_W_P * (V_ACTIVE >> SCALE_SHIFT);
    localparam logic [9:0]  LOW_MASK   = 10'((1 << SCALE_SHIFT) - 1);

    logic              active;
    logic              rd_slot;
    logic [ADDR_W-1:0] rd_addr;

    scan_state_e       state_d, state_q;
    logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
    logic              mem_we_d, mem_we_q;

    logic              rd_ret_q;
    logic [DATA_W-1:0] hold_q, pix;
    logic [2:0]        sync_mid;
    logic [23:0]       rgb_d, rgb_q;
    logic [2:0]        sync_q;
    logic              frame_start_q;

    assign active  = (32'(hcount) < H_ACTIVE) && (32'(vcount) < V_ACTIVE);
    assign rd_slot = active && ((hcount & LOW_MASK) == '0);
    assign rd_addr = ADDR_W'(((32'(vcount) >> SCALE_SHIFT) * FB_W_P) + (32'(hcount) >> SCALE_SHIFT));

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= BLANK;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    // State is the counter classification of the current cycle; the registered
    // copy marks a read in flight at the memory stage.
    always_comb begin
        state_d      = BLANK;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        bus.wr_ready = 1'b0;
        if (active) state_d = rd_slot ? SCAN_RD : SCAN_GAP;
        unique case (state_d)
            SCAN_RD: begin
                mem_addr_d = rd_addr;
            end
            SCAN_GAP, BLANK: begin
                bus.wr_ready = 1'b1;
                if (bus.wr_valid && (32'(bus.wr_addr) < FB_WORDS_P)) begin
                    mem_addr_d  = bus.wr_addr;
                    mem_wdata_d = bus.wr_data;
                    mem_we_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;

    // Fresh read data bypasses the hold register so the read pixel itself
    // lands on the pins at t+3; replicated pixels come from hold.
    assign pix = rd_ret_q ? bus.mem_rdata : hold_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ret_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            rd_ret_q <= (state_q == SCAN_RD);
            hold_q   <= pix;
        end
    end

    // Two stages here plus the output register below give the 3-cycle alignment.
    sync_delay #(
        .DEPTH     (2),
        .WIDTH     (3),
        .RESET_VAL (3'b110)
    ) u_sync_delay (
        .clk   (vga_clk),
        .rst_n (reset_n),
        .d_i   ({hs_in, vs_in, blank_n_in}),
        .q_o   (sync_mid)
    );

`ifdef FB_BORDER_EN
    logic [9:0] h_dly_q [2];
    logic [9:0] v_dly_q [2];
    logic       on_border;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_dly_q[0] <= '0;
            h_dly_q[1] <= '0;
            v_dly_q[0] <= '0;
            v_dly_q[1] <= '0;
        end else begin
            h_dly_q[0] <= hcount;
            h_dly_q[1] <= h_dly_q[0];
            v_dly_q[0] <= vcount;
            v_dly_q[1] <= v_dly_q[0];
        end
    end

    assign on_border = (h_dly_q[1] == '0) || (32'(h_dly_q[1]) == H_ACTIVE - 1) ||
                       (v_dly_q[1] == '0) || (32'(v_dly_q[1]) == V_ACTIVE - 1);
`endif

    always_comb begin
        rgb_d = '0;
        if (sync_mid[0]) begin
            rgb_d = expand_rgb332(rgb332_t'(pix[7:0]));
`ifdef FB_BORDER_EN
            if (on_border) rgb_d = '1;
`endif
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q         <= '0;
            sync_q        <= 3'b110;
            frame_start_q <= 1'b0;
        end else begin
            rgb_q         <= rgb_d;
            sync_q        <= sync_mid;
            frame_start_q <= (hcount == '0) && (vcount == '0);
        end
    end

    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign vga_hs      = sync_q[2];
    assign vga_vs      = sync_q[1];
    assign vga_blank_n = sync_q[0];
    assign frame_start = frame_start_q;

endmodule
